// File: rtl/core_pkg.sv
// Shared RISC-V decode constants and immediate extractors.
// Extractors return 64-bit sign-extended values; callers cast down to XLEN.
package core_pkg;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  function automatic logic [63:0] imm_i(input logic [31:0] inst);
    return {{52{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [63:0] imm_s(input logic [31:0] inst);
    return {{52{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [63:0] imm_b(input logic [31:0] inst);
    return {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [63:0] imm_u(input logic [31:0] inst);
    return {{32{inst[31]}}, inst[31:12], 12'b0};
  endfunction

  function automatic logic [63:0] imm_j(input logic [31:0] inst);
    return {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// DEPTH-entry {PC, INST} FIFO with valid/ready handshake and synchronous flush.
module decode_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_inst,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN+31:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign level     = count;
  assign {out_pc, out_inst} = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_pc, in_inst};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/decode_1_pipe.sv
// First decode stage: FIFO buffering plus field split and XLEN immediates of the head.
// Optional head legality check enabled by DECODE1_ILLEGAL_CHECK_EN.
module decode_1_pipe
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FLUSH,
  input  logic                       INST_VALID,
  output logic                       INST_READY,
  input  logic [XLEN-1:0]            INST_PC,
  input  logic [31:0]                INST_DATA,
  output logic                       DECODE1_VALID,
  input  logic                       DECODE1_READY,
  output logic [XLEN-1:0]            DECODE1_PC,
  output logic [6:0]                 DECODE1_OPCODE,
  output logic [4:0]                 DECODE1_RD,
  output logic [4:0]                 DECODE1_RS1,
  output logic [4:0]                 DECODE1_RS2,
  output logic [2:0]                 DECODE1_FUNCT3,
  output logic [6:0]                 DECODE1_FUNCT7,
  output logic [XLEN-1:0]            DECODE1_IMM_I,
  output logic [XLEN-1:0]            DECODE1_IMM_S,
  output logic [XLEN-1:0]            DECODE1_IMM_B,
  output logic [XLEN-1:0]            DECODE1_IMM_U,
  output logic [XLEN-1:0]            DECODE1_IMM_J,
  output logic [$clog2(DEPTH+1)-1:0] DECODE1_LEVEL,
  output logic                       DECODE1_ILLEGAL
);

  logic [31:0] inst;

  decode_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (RST),
    .flush     (FLUSH),
    .in_valid  (INST_VALID),
    .in_ready  (INST_READY),
    .in_pc     (INST_PC),
    .in_inst   (INST_DATA),
    .out_valid (DECODE1_VALID),
    .out_ready (DECODE1_READY),
    .out_pc    (DECODE1_PC),
    .out_inst  (inst),
    .level     (DECODE1_LEVEL)
  );

  assign DECODE1_OPCODE = inst[6:0];
  assign DECODE1_RD     = inst[11:7];
  assign DECODE1_FUNCT3 = inst[14:12];
  assign DECODE1_RS1    = inst[19:15];
  assign DECODE1_RS2    = inst[24:20];
  assign DECODE1_FUNCT7 = inst[31:25];

  assign DECODE1_IMM_I = XLEN'(imm_i(inst));
  assign DECODE1_IMM_S = XLEN'(imm_s(inst));
  assign DECODE1_IMM_B = XLEN'(imm_b(inst));
  assign DECODE1_IMM_U = XLEN'(imm_u(inst));
  assign DECODE1_IMM_J = XLEN'(imm_j(inst));

`ifdef DECODE1_ILLEGAL_CHECK_EN
  logic known;

  always_comb begin
    known = 1'b0;
    case (inst[6:0])
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
      OPCODE_LOAD, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_OP,
      OPCODE_MISC_MEM, OPCODE_SYSTEM: known = 1'b1;
      default:                        known = 1'b0;
    endcase
  end

  assign DECODE1_ILLEGAL = DECODE1_VALID & ((inst[1:0] != 2'b11) | ~known);
`else
  assign DECODE1_ILLEGAL = 1'b0;
`endif

endmodule

// File: tb/tb_decode_1_pipe.sv
// Directed self-checking bench for decode_1_pipe (XLEN=32 and XLEN=64 instances).
module tb_decode_1_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FLUSH = 1'b0;
  logic        INST_VALID = 1'b0;
  logic [31:0] INST_PC = '0;
  logic [31:0] INST_DATA = '0;
  logic        DECODE1_READY = 1'b0;

  logic        INST_READY, VALID, ILLEGAL;
  logic [31:0] PC, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J;
  logic [6:0]  OPCODE, FUNCT7;
  logic [4:0]  RD, RS1, RS2;
  logic [2:0]  FUNCT3;
  logic [1:0]  LEVEL;

  logic        r64, v64, ill64;
  logic [63:0] pc64, i64, s64, b64, u64, j64;
  logic [6:0]  op64, f7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64;
  logic [1:0]  lvl64;

  int checks = 0;
  int fails  = 0;
  logic exp_ill;

  always #5 CLK = ~CLK;

  decode_1_pipe #(.XLEN(32), .DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .INST_VALID(INST_VALID), .INST_READY(INST_READY),
    .INST_PC(INST_PC), .INST_DATA(INST_DATA),
    .DECODE1_VALID(VALID), .DECODE1_READY(DECODE1_READY),
    .DECODE1_PC(PC), .DECODE1_OPCODE(OPCODE), .DECODE1_RD(RD),
    .DECODE1_RS1(RS1), .DECODE1_RS2(RS2), .DECODE1_FUNCT3(FUNCT3),
    .DECODE1_FUNCT7(FUNCT7), .DECODE1_IMM_I(IMM_I), .DECODE1_IMM_S(IMM_S),
    .DECODE1_IMM_B(IMM_B), .DECODE1_IMM_U(IMM_U), .DECODE1_IMM_J(IMM_J),
    .DECODE1_LEVEL(LEVEL), .DECODE1_ILLEGAL(ILLEGAL)
  );

  decode_1_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .INST_VALID(INST_VALID), .INST_READY(r64),
    .INST_PC({32'h0000_0001, INST_PC}), .INST_DATA(INST_DATA),
    .DECODE1_VALID(v64), .DECODE1_READY(DECODE1_READY),
    .DECODE1_PC(pc64), .DECODE1_OPCODE(op64), .DECODE1_RD(rd64),
    .DECODE1_RS1(rs1_64), .DECODE1_RS2(rs2_64), .DECODE1_FUNCT3(f3_64),
    .DECODE1_FUNCT7(f7_64), .DECODE1_IMM_I(i64), .DECODE1_IMM_S(s64),
    .DECODE1_IMM_B(b64), .DECODE1_IMM_U(u64), .DECODE1_IMM_J(j64),
    .DECODE1_LEVEL(lvl64), .DECODE1_ILLEGAL(ill64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] data);
    INST_VALID = v;
    INST_PC    = pc;
    INST_DATA  = data;
  endtask

  initial begin
`ifdef DECODE1_ILLEGAL_CHECK_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    #3;
    chk("rst_valid", 64'(VALID), 64'(0));
    chk("rst_ready", 64'(INST_READY), 64'(1));
    chk("rst_level", 64'(LEVEL), 64'(0));
    chk("rst_illegal", 64'(ILLEGAL), 64'(0));
    chk("rst_pc", 64'(PC), 64'(0));
    chk("rst_imm_i", 64'(IMM_I), 64'(0));
    chk("rst_rd", 64'(RD), 64'(0));
    chk("rst_pc64", pc64, 64'(0));
    tick();
    RST = 1'b1;
    tick();

    // single push, next-cycle visibility, then pop
    DECODE1_READY = 1'b1;
    offer(1'b1, 32'h100, 32'hFFF0_0093);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    chk("t1_valid", 64'(VALID), 64'(1));
    chk("t1_pc", 64'(PC), 64'h100);
    chk("t1_rd", 64'(RD), 64'(1));
    chk("t1_opcode", 64'(OPCODE), 64'h13);
    chk("t1_rs1", 64'(RS1), 64'(0));
    chk("t1_imm_i", 64'(IMM_I), 64'hFFFF_FFFF);
    chk("t1_imm_i64", i64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_pc64", pc64, 64'h0000_0001_0000_0100);
    chk("t1_level", 64'(LEVEL), 64'(1));
    chk("t1_illegal", 64'(ILLEGAL), 64'(0));
    tick();
    chk("t1_pop_level", 64'(LEVEL), 64'(0));
    chk("t1_pop_valid", 64'(VALID), 64'(0));

    // three back-to-back offers with decode 2 stalled
    DECODE1_READY = 1'b0;
    offer(1'b1, 32'h200, 32'h0010_0113);
    tick();
    offer(1'b1, 32'h204, 32'h0020_0193);
    tick();
    chk("t2_ready_full", 64'(INST_READY), 64'(0));
    offer(1'b1, 32'h208, 32'h0030_0213);
    tick();
    chk("t2_level", 64'(LEVEL), 64'(2));
    chk("t2_ready", 64'(INST_READY), 64'(0));
    chk("t2_head_pc", 64'(PC), 64'h200);
    chk("t2_head_rd", 64'(RD), 64'(2));
    chk("t2_head_imm_i", 64'(IMM_I), 64'(1));

    // full: pop accepted, same-cycle offer refused
    DECODE1_READY = 1'b1;
    tick();
    chk("t3_level", 64'(LEVEL), 64'(1));
    chk("t3_ready", 64'(INST_READY), 64'(1));
    chk("t3_head_pc", 64'(PC), 64'h204);
    DECODE1_READY = 1'b0;
    tick();
    chk("t3_refill_level", 64'(LEVEL), 64'(2));
    chk("t3_refill_head", 64'(PC), 64'h204);

    // flush at LEVEL=2 with a same-cycle offer
    FLUSH = 1'b1;
    offer(1'b1, 32'h300, 32'h0050_0293);
    tick();
    FLUSH = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    chk("t4_valid", 64'(VALID), 64'(0));
    chk("t4_level", 64'(LEVEL), 64'(0));
    chk("t4_ready", 64'(INST_READY), 64'(1));
    chk("t4_illegal", 64'(ILLEGAL), 64'(0));

    // flush at LEVEL=1 discards an accepted push and a pop
    offer(1'b1, 32'h400, 32'h0060_0313);
    tick();
    FLUSH = 1'b1;
    DECODE1_READY = 1'b1;
    offer(1'b1, 32'h404, 32'h0070_0393);
    tick();
    FLUSH = 1'b0;
    DECODE1_READY = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    chk("t4b_level", 64'(LEVEL), 64'(0));
    chk("t4b_valid", 64'(VALID), 64'(0));

    // B-type, then J and U immediates behind it
    offer(1'b1, 32'h500, 32'hFE00_0EE3);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    chk("t5_head_pc", 64'(PC), 64'h500);
    chk("t5_imm_b", 64'(IMM_B), 64'hFFFF_FFFC);
    chk("t5_imm_b64", b64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t5_funct7", 64'(FUNCT7), 64'h7F);
    chk("t5_opcode", 64'(OPCODE), 64'h63);
    DECODE1_READY = 1'b1;
    offer(1'b1, 32'h504, 32'hFFDF_F06F);
    tick();
    chk("t5_imm_j", 64'(IMM_J), 64'hFFFF_FFFC);
    chk("t5_imm_j64", j64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t5_pp_level", 64'(LEVEL), 64'(1));
    offer(1'b1, 32'h508, 32'h8000_00B7);
    tick();
    chk("t5_imm_u", 64'(IMM_U), 64'h8000_0000);
    chk("t5_imm_u64", u64, 64'hFFFF_FFFF_8000_0000);
    chk("t5_u_pc", 64'(PC), 64'h508);

    // illegal check
    offer(1'b1, 32'h600, 32'h0000_0000);
    tick();
    chk("t6_zero_pc", 64'(PC), 64'h600);
    chk("t6_zero_illegal", 64'(ILLEGAL), 64'(exp_ill));
    offer(1'b1, 32'h604, 32'h0000_0013);
    tick();
    chk("t6_nop_pc", 64'(PC), 64'h604);
    chk("t6_nop_illegal", 64'(ILLEGAL), 64'(0));
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk("t6_empty_valid", 64'(VALID), 64'(0));
    chk("t6_empty_illegal", 64'(ILLEGAL), 64'(0));
    chk("t6_empty_level64", 64'(lvl64), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
